error_eval_acc: RTL
===================

ERROR_EVAL_ACC -- requirements
Module: error_eval_acc

Interface
REQ-001 SHALL have parameter OUT_W, default 9, the width of the adder result words compared.
REQ-002 SHALL have parameter CNT_W, default 17, the width of the sample and mismatch counters (sized for 2^16 input vectors).
REQ-003 SHALL have parameter SUM_W, default 26, the width of the sum-of-absolute-error accumulator.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that clears the metrics and begins a run.
REQ-007 SHALL have port in_valid, input, 1 bit: exact/approx/in_last are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port exact, input, OUT_W bits: golden adder result.
REQ-010 SHALL have port approx, input, OUT_W bits: approximate adder result for the same operands.
REQ-011 SHALL have port in_last, input, 1 bit: final sample of the run.
REQ-012 SHALL have port sample_count, output, CNT_W bits: number of samples accumulated.
REQ-013 SHALL have port err_count, output, CNT_W bits: number of samples with exact != approx.
REQ-014 SHALL have port sum_abs_err, output, SUM_W bits: sum of |exact - approx|.
REQ-015 SHALL have port max_abs_err, output, OUT_W bits: largest |exact - approx| seen.
REQ-016 SHALL have port busy, output, 1 bit: the FSM is in RUN or draining.
REQ-017 SHALL have port done, output, 1 bit: metrics are final and stable.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag, set when any counter saturated.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; the reset state is IDLE.
REQ-020 SHALL transition IDLE->RUN and DONE->RUN on start=1, clearing all metrics and overflow in that same cycle; start SHALL be ignored in RUN and DRAIN.
REQ-021 SHALL drive in_ready=1 only in RUN; a sample is accepted when in_valid & in_ready.
REQ-022 SHALL, in pipeline stage 1, register the accepted sample's absolute difference (unsigned, OUT_W bits, computed in OUT_W+1 bits) and its mismatch bit.
REQ-023 SHALL, in stage 2 (one cycle later), increment sample_count, add mismatch to err_count, add the difference to sum_abs_err, and update max_abs_err when the difference is strictly greater; metric latency is 2 cycles from acceptance.
REQ-024 SHALL transition RUN->DRAIN on acceptance with in_last=1, and DRAIN->DONE once stage 2 retires the last sample, so done rises 2 cycles after the in_last acceptance.
REQ-025 SHALL hold done=1 and the metrics constant throughout DONE; busy=1 in RUN and DRAIN only.
REQ-026 SHALL saturate each counter and the accumulator at all-ones instead of wrapping, and set overflow, which stays set until start or rst.
REQ-027 SHALL leave the metrics unchanged in a cycle where in_valid=1 but in_ready=0; back-to-back acceptance every cycle SHALL be supported without loss.
REQ-028 SHALL, when start and rst are high in the same cycle, give rst priority.

Reset
REQ-029 SHALL, on rst=1 at a clock edge (including mid-run), set the state to IDLE, clear the pipeline valid bits, and set every output to 0 (in_ready, busy, done, overflow, and all metrics); samples in flight are discarded.

Verification
REQ-030 SHALL pass: start, then 4 samples (exact,approx) = (10,10),(20,18),(5,9),(511,0) with in_last on the 4th -> done 2 cycles after the 4th acceptance; sample_count=4, err_count=3, sum_abs_err=517, max_abs_err=511.
REQ-031 SHALL pass: exhaustive 65536-sample run with approx=exact -> sample_count=65536, err_count=0, sum_abs_err=0, overflow=0.
REQ-032 SHALL pass: in_valid toggled randomly for 100 samples -> sample_count=100 and no duplicated or lost samples versus the reference model.
REQ-033 SHALL pass: rst asserted 1 cycle after the 3rd acceptance -> next cycle all outputs 0 and state IDLE; a subsequent start plus a 1-sample run yields sample_count=1.
REQ-034 SHALL pass: with CNT_W=3, a 10-sample all-mismatch run -> sample_count=7, err_count=7, overflow=1.
REQ-035 SHALL pass: start pulsed during RUN -> ignored with metrics intact; start in DONE -> metrics cleared and in_ready=1 the next cycle.

Source files
------------

// File: rtl/error_eval_acc.sv
// ---------------------------------------------------------------------------
// error_eval_acc
//
// Accumulates error metrics comparing an approximate adder against its exact
// reference, one sample pair per accepted handshake. A run is opened by a
// start pulse and closed by a sample tagged in_last. Each sample passes
// through two pipeline stages:
//   stage 1: register |exact - approx| and the mismatch bit
//   stage 2: fold them into the running counters / accumulator / maximum
// so metrics reflect a sample two cycles after its acceptance.
//
// Ports
//   clk          : clock, all state on rising edge
//   rst          : synchronous active-high reset (wins over start)
//   start        : one-cycle pulse, clears metrics and opens a run (IDLE/DONE)
//   in_valid     : exact/approx/in_last carry a sample
//   in_ready     : sample accepted this cycle when in_valid is also high
//   exact        : golden adder result
//   approx       : approximate adder result for the same operands
//   in_last      : final sample of the run
//   sample_count : samples accumulated (saturating)
//   err_count    : samples with exact != approx (saturating)
//   sum_abs_err  : sum of |exact - approx| (saturating)
//   max_abs_err  : largest |exact - approx| seen in the run
//   busy         : run open or pipeline draining
//   done         : metrics final and stable
//   overflow     : sticky, some counter/accumulator hit all-ones
// ---------------------------------------------------------------------------
module error_eval_acc #(
    parameter int OUT_W = 9,
    parameter int CNT_W = 17,
    parameter int SUM_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] exact,
    input  logic [OUT_W-1:0] approx,
    input  logic             in_last,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [OUT_W-1:0] max_abs_err,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // FSM
    logic [1:0] state_q, state_d;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_diff_q,  s1_diff_d;
    logic             s1_mis_q,   s1_mis_d;
    logic             s1_last_q,  s1_last_d;

    // Stage 2 metrics
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q,    err_count_d;
    logic [SUM_W-1:0] sum_abs_err_q,  sum_abs_err_d;
    logic [OUT_W-1:0] max_abs_err_q,  max_abs_err_d;
    logic             overflow_q,     overflow_d;

    // Combinational helpers
    logic             accept;
    logic             start_ok;
    logic [OUT_W:0]   diff_wide;
    logic [OUT_W-1:0] abs_diff;
    logic [CNT_W:0]   sc_inc;
    logic [CNT_W:0]   ec_inc;
    logic [SUM_W:0]   sum_inc;

    // -----------------------------------------------------------------------
    // Handshake and start qualification
    // -----------------------------------------------------------------------
    always_comb begin
        accept   = in_valid && (state_q == ST_RUN);
        start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // -----------------------------------------------------------------------
    // Absolute difference: the sign of the OUT_W+1 bit difference selects
    // between the direct low bits and the reversed subtraction, so the
    // magnitude always fits in OUT_W bits.
    // -----------------------------------------------------------------------
    always_comb begin
        diff_wide = {1'b0, exact} - {1'b0, approx};
        if (diff_wide[OUT_W]) begin
            abs_diff = approx - exact;
        end else begin
            abs_diff = diff_wide[OUT_W-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: capture the accepted sample
    // -----------------------------------------------------------------------
    always_comb begin
        s1_valid_d = accept;
        s1_last_d  = accept && in_last;
        s1_diff_d  = s1_diff_q;
        s1_mis_d   = s1_mis_q;
        if (accept) begin
            s1_diff_d = abs_diff;
            s1_mis_d  = (exact != approx);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: saturating accumulation. One extra bit on each sum exposes
    // the carry that would otherwise wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        sc_inc  = (CNT_W+1)'(sample_count_q) + (CNT_W+1)'(1);
        ec_inc  = (CNT_W+1)'(err_count_q) + (CNT_W+1)'(s1_mis_q);
        sum_inc = (SUM_W+1)'(sum_abs_err_q) + (SUM_W+1)'(s1_diff_q);
    end

    always_comb begin
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        sum_abs_err_d  = sum_abs_err_q;
        max_abs_err_d  = max_abs_err_q;
        overflow_d     = overflow_q;

        if (start_ok) begin
            // Pipeline is empty in IDLE/DONE, so clearing cannot lose a sample
            sample_count_d = '0;
            err_count_d    = '0;
            sum_abs_err_d  = '0;
            max_abs_err_d  = '0;
            overflow_d     = 1'b0;
        end else if (s1_valid_q) begin
            if (sc_inc[CNT_W]) begin
                sample_count_d = '1;
                overflow_d     = 1'b1;
            end else begin
                sample_count_d = sc_inc[CNT_W-1:0];
            end

            if (ec_inc[CNT_W]) begin
                err_count_d = '1;
                overflow_d  = 1'b1;
            end else begin
                err_count_d = ec_inc[CNT_W-1:0];
            end

            if (sum_inc[SUM_W]) begin
                sum_abs_err_d = '1;
                overflow_d    = 1'b1;
            end else begin
                sum_abs_err_d = sum_inc[SUM_W-1:0];
            end

            if (s1_diff_q > max_abs_err_q) begin
                max_abs_err_d = s1_diff_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: DRAIN waits for the last sample to leave stage 2, which happens
    // on the edge after its acceptance, so done rises two cycles later.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s1_valid_q && s1_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            s1_valid_q     <= 1'b0;
            s1_diff_q      <= '0;
            s1_mis_q       <= 1'b0;
            s1_last_q      <= 1'b0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            sum_abs_err_q  <= '0;
            max_abs_err_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_valid_q     <= s1_valid_d;
            s1_diff_q      <= s1_diff_d;
            s1_mis_q       <= s1_mis_d;
            s1_last_q      <= s1_last_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            sum_abs_err_q  <= sum_abs_err_d;
            max_abs_err_q  <= max_abs_err_d;
            overflow_q     <= overflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready     = (state_q == ST_RUN);
        busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done         = (state_q == ST_DONE);
        overflow     = overflow_q;
        sample_count = sample_count_q;
        err_count    = err_count_q;
        sum_abs_err  = sum_abs_err_q;
        max_abs_err  = max_abs_err_q;
    end

endmodule
